// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the 4:1 serializer and 1:4 demultiplexer.
// Beat 0 carries the most-significant slice of the wide word.
package tdm_pkg;

  localparam int TDM_RATIO = 4;

  typedef logic [1:0] tdm_beat_t;

  // MSB bit position of the slice that beat k occupies in the wide word
  function automatic int tdm_slice_msb(input int k, input int width);
    return (TDM_RATIO - k) * width - 1;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Narrow-beat input and wide-word output handshakes of the TDM demultiplexer.
// The slave modport is the demux view; master is the upstream/downstream side.
interface tdm_demux_if #(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 4 * WIDTH_IN
);
    logic [WIDTH_IN-1:0]  i_data_in;
    logic                 i_valid_in;
    logic                 i_ready_out;
    logic [WIDTH_OUT-1:0] o_data_out;
    logic                 o_valid_out;
    logic                 o_ready_in;
    logic                 o_partial_out;

    modport slave (
        input  i_data_in, i_valid_in, o_ready_in,
        output i_ready_out, o_data_out, o_valid_out, o_partial_out
    );

    modport master (
        output i_data_in, i_valid_in, o_ready_in,
        input  i_ready_out, o_data_out, o_valid_out, o_partial_out
    );
endinterface

// File: rtl/tdm_out_buffer.sv
// Two-entry in-order FIFO of {partial, data}; entry0 is always the head.
// Simultaneous push and pop keep the count and preserve ordering.
module tdm_out_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH:0]   push_entry,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_partial,
    output logic             empty,
    output logic             full
);
    logic [WIDTH:0] entry0;
    logic [WIDTH:0] entry1;
    logic [1:0]     count;

    assign head_partial = entry0[WIDTH];
    assign head_data    = entry0[WIDTH-1:0];
    assign empty        = (count == 2'd0);
    assign full         = (count == 2'd2);

    // NOTE: the storage is reset too, because the head entry drives o_data_out,
    // which must read zero after reset.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_entry;
                    else               entry1 <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_entry;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/tdm_demux.sv
// 1:4 TDM demultiplexer: reassembles four narrow beats (MSB slice first) into a
// wide word, flushing stalled partial groups zero-filled after an idle timeout.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH_IN       = 4,
    parameter int WIDTH_OUT      = TDM_RATIO * WIDTH_IN,
    parameter int TIMEOUT_CYCLES = 8
) (
    input logic        clk_fast,
    input logic        rst,
    tdm_demux_if.slave bus
);
    localparam int               IDLE_W    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam tdm_beat_t        LAST_BEAT = tdm_beat_t'(TDM_RATIO - 1);

    tdm_beat_t            cnt;
    logic [IDLE_W-1:0]    idle;
    logic [WIDTH_OUT-1:0] asm_q;
    logic                 buf_full;
    logic                 buf_empty;
    logic                 accept;
    logic                 group_done;
    logic                 flush_pending;
    logic                 push;
    logic [WIDTH_OUT:0]   push_entry;

    // Ready depends only on registered state, never on o_ready_in.
    assign flush_pending   = (TIMEOUT_CYCLES != 0) && (cnt != '0) && (idle == IDLE_MAX);
    assign bus.i_ready_out = ~rst & ~flush_pending & ~(buf_full & (cnt == LAST_BEAT));
    assign accept          = bus.i_valid_in & bus.i_ready_out;
    assign group_done      = accept & (cnt == LAST_BEAT);
    assign push            = group_done | (flush_pending & ~buf_full);
    assign push_entry      = group_done ? {1'b0, asm_q[WIDTH_OUT-1:WIDTH_IN], bus.i_data_in}
                                        : {1'b1, asm_q};

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idle  <= '0;
            asm_q <= '0;
        end else if (push) begin
            cnt   <= '0;
            idle  <= '0;
            asm_q <= '0;
        end else if (accept) begin
            cnt  <= cnt + 1'b1;
            idle <= '0;
            for (int k = 0; k < TDM_RATIO - 1; k++) begin
                if (cnt == tdm_beat_t'(k))
                    asm_q[tdm_slice_msb(k, WIDTH_IN) -: WIDTH_IN] <= bus.i_data_in;
            end
        end else if (cnt == '0) begin
            idle <= '0;
        end else if (idle != IDLE_MAX) begin
            idle <= idle + 1'b1;
        end
    end

    tdm_out_buffer #(.WIDTH(WIDTH_OUT)) u_out_buffer (
        .clk_fast     (clk_fast),
        .rst          (rst),
        .push         (push),
        .push_entry   (push_entry),
        .pop          (bus.o_valid_out & bus.o_ready_in),
        .head_data    (bus.o_data_out),
        .head_partial (bus.o_partial_out),
        .empty        (buf_empty),
        .full         (buf_full)
    );

    assign bus.o_valid_out = ~buf_empty;
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: directed beat groups push expected words,
// per-instance monitors pop and compare on every output handshake.
module tb_tdm_demux;
    logic clk_fast = 1'b0;
    logic rst      = 1'b1;
    int   n_cmp    = 0;
    int   n_err    = 0;

    logic [16:0] exp_a[$];
    logic [16:0] exp_b[$];

    always #5 clk_fast = ~clk_fast;

    tdm_demux_if #(.WIDTH_IN(4)) a ();
    tdm_demux_if #(.WIDTH_IN(4)) b ();

    tdm_demux #(.WIDTH_IN(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .bus      (a.slave)
    );

    tdm_demux #(.WIDTH_IN(4), .TIMEOUT_CYCLES(0)) dut_nt (
        .clk_fast (clk_fast),
        .rst      (rst),
        .bus      (b.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_fast) begin
        if (!rst && a.o_valid_out && a.o_ready_in) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected_word: got %h, no word expected", {a.o_partial_out, a.o_data_out});
            end else begin
                check("a_word", {15'd0, a.o_partial_out, a.o_data_out}, {15'd0, exp_a.pop_front()});
            end
        end
    end

    always @(negedge clk_fast) begin
        if (!rst && b.o_valid_out && b.o_ready_in) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected_word: got %h, no word expected", {b.o_partial_out, b.o_data_out});
            end else begin
                check("b_word", {15'd0, b.o_partial_out, b.o_data_out}, {15'd0, exp_b.pop_front()});
            end
        end
    end

    // Holds one beat until accepted; returns at the accepting edge + 1.
    task automatic send(input bit sel, input logic [3:0] d);
        bit done = 1'b0;
        if (sel) begin b.i_data_in = d; b.i_valid_in = 1'b1; end
        else     begin a.i_data_in = d; a.i_valid_in = 1'b1; end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_fast);
            if (sel ? b.i_ready_out : a.i_ready_out) done = 1'b1;
            @(posedge clk_fast);
            #1;
        end
        if (sel) b.i_valid_in = 1'b0;
        else     a.i_valid_in = 1'b0;
        if (!done) check("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain(input bit sel);
        for (int i = 0; i < 60 && (sel ? exp_b.size() : exp_a.size()) != 0; i++)
            @(posedge clk_fast);
        #1;
        check(sel ? "b_drained" : "a_drained", sel ? exp_b.size() : exp_a.size(), 32'd0);
    endtask

    task automatic step();
        @(posedge clk_fast);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int rcnt;
        a.i_data_in = '0; a.i_valid_in = 1'b0; a.o_ready_in = 1'b0;
        b.i_data_in = '0; b.i_valid_in = 1'b0; b.o_ready_in = 1'b1;

        // Reset state
        repeat (2) @(posedge clk_fast);
        #1;
        check("rst_ready",   32'(a.i_ready_out),   32'd0);
        check("rst_valid",   32'(a.o_valid_out),   32'd0);
        check("rst_partial", 32'(a.o_partial_out), 32'd0);
        check("rst_data",    32'(a.o_data_out),    32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(a.i_ready_out), 32'd1);

        // 1: single group, valid pulse one cycle after the 4th accept
        a.o_ready_in = 1'b1;
        exp_a.push_back({1'b0, 16'h9ABC});
        send(0, 4'h9); send(0, 4'hA); send(0, 4'hB); send(0, 4'hC);
        check("t1_valid_next_cycle", 32'(a.o_valid_out),   32'd1);
        check("t1_partial",          32'(a.o_partial_out), 32'd0);
        step();
        check("t1_valid_one_cycle",  32'(a.o_valid_out),   32'd0);
        drain(0);

        // 2: backpressure fills buffer, 4th beat of third group held off
        a.o_ready_in = 1'b0;
        exp_a.push_back({1'b0, 16'h9ABC});
        exp_a.push_back({1'b0, 16'h8123});
        exp_a.push_back({1'b0, 16'hDEF4});
        send(0, 4'h9); send(0, 4'hA); send(0, 4'hB); send(0, 4'hC);
        send(0, 4'h8); send(0, 4'h1); send(0, 4'h2); send(0, 4'h3);
        send(0, 4'hD); send(0, 4'hE); send(0, 4'hF);
        check("t2_head_data", 32'(a.o_data_out), 32'h9ABC);
        a.i_data_in = 4'h4; a.i_valid_in = 1'b1;
        @(negedge clk_fast);
        check("t2_ready_low_full", 32'(a.i_ready_out), 32'd0);
        step();
        @(negedge clk_fast);
        check("t2_ready_still_low", 32'(a.i_ready_out), 32'd0);
        step();
        a.o_ready_in = 1'b1;
        send(0, 4'h4);
        drain(0);

        // 3: partial group flushed after 8 idle cycles
        exp_a.push_back({1'b1, 16'h9A00});
        send(0, 4'h9); send(0, 4'hA);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 7) check("t3_ready_before_timeout", 32'(a.i_ready_out), 32'd1);
            if (k == 8) begin
                check("t3_ready_at_timeout", 32'(a.i_ready_out), 32'd0);
                check("t3_no_valid_yet",     32'(a.o_valid_out), 32'd0);
            end
        end
        step();
        check("t3_flush_valid",   32'(a.o_valid_out),   32'd1);
        check("t3_flush_partial", 32'(a.o_partial_out), 32'd1);
        check("t3_ready_back",    32'(a.i_ready_out),   32'd1);
        drain(0);

        // 4: push and pop in the same cycle keep the count at one
        a.o_ready_in = 1'b0;
        exp_a.push_back({1'b0, 16'h5678});
        exp_a.push_back({1'b0, 16'hABCD});
        send(0, 4'h5); send(0, 4'h6); send(0, 4'h7); send(0, 4'h8);
        send(0, 4'hA); send(0, 4'hB); send(0, 4'hC);
        a.i_data_in = 4'hD; a.i_valid_in = 1'b1; a.o_ready_in = 1'b1;
        @(negedge clk_fast);
        check("t4_ready_last_beat", 32'(a.i_ready_out), 32'd1);
        step();
        a.i_valid_in = 1'b0; a.o_ready_in = 1'b0;
        check("t4_valid_after_swap", 32'(a.o_valid_out), 32'd1);
        check("t4_head_after_swap",  32'(a.o_data_out),  32'hABCD);
        a.o_ready_in = 1'b1;
        step();
        check("t4_count_was_one", 32'(a.o_valid_out), 32'd0);
        drain(0);

        // 5: reset mid-group discards the partial beats
        send(0, 4'h7); send(0, 4'h6);
        rst = 1'b1;
        #1;
        check("t5_ready_in_rst", 32'(a.i_ready_out), 32'd0);
        check("t5_valid_in_rst", 32'(a.o_valid_out), 32'd0);
        step();
        rst = 1'b0;
        exp_a.push_back({1'b0, 16'h1234});
        send(0, 4'h1); send(0, 4'h2); send(0, 4'h3); send(0, 4'h4);
        drain(0);

        // 6: timeout disabled, partial group waits indefinitely
        exp_b.push_back({1'b0, 16'h3579});
        send(1, 4'h3); send(1, 4'h5); send(1, 4'h7);
        vcnt = 0;
        rcnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (b.o_valid_out) vcnt++;
            if (!b.i_ready_out) rcnt++;
        end
        check("t6_no_flush_valid", 32'(vcnt), 32'd0);
        check("t6_ready_held",     32'(rcnt), 32'd0);
        send(1, 4'h9);
        check("t6_word_valid", 32'(b.o_valid_out), 32'd1);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
